// File: rtl/mem_arbiter.sv
// Two-port (I-cache / D-cache) arbiter in front of one shared block memory; grant costs >= 3 cycles.
// Requesters stall on x_BUSYWAIT until DONE_x; fixed D priority, or round-robin with MEM_ARBITER_ROUND_ROBIN_EN.
module mem_arbiter #(
    parameter int ADDR_W  = 28,
    parameter int BLOCK_W = 128
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               I_READ,
    input  logic [ADDR_W-1:0]  I_ADDRESS,
    output logic [BLOCK_W-1:0] I_READDATA,
    output logic               I_BUSYWAIT,
    input  logic               D_READ,
    input  logic               D_WRITE,
    input  logic [ADDR_W-1:0]  D_ADDRESS,
    input  logic [BLOCK_W-1:0] D_WRITEDATA,
    output logic [BLOCK_W-1:0] D_READDATA,
    output logic               D_BUSYWAIT,
    output logic               MEM_READ,
    output logic               MEM_WRITE,
    output logic [ADDR_W-1:0]  MEM_ADDRESS,
    output logic [BLOCK_W-1:0] MEM_WRITEDATA,
    input  logic [BLOCK_W-1:0] MEM_READDATA,
    input  logic               MEM_BUSYWAIT
);

    typedef enum logic [2:0] {IDLE, GRANT_I, GRANT_D, DONE_I, DONE_D} state_t;

    state_t state, state_nxt;
    logic   first_cyc;
    logic   i_pend, d_pend, pick_d, complete;

    assign i_pend = I_READ;
    assign d_pend = D_READ | D_WRITE;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    logic last_d;

    assign pick_d = d_pend && (!i_pend || !last_d);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET)
            last_d <= 1'b0;
        else if (state == IDLE && (i_pend || d_pend))
            last_d <= pick_d;
    end
`else
    assign pick_d = d_pend;
`endif

    // Memory busywait during the first grant cycle is stale (memory has not seen the request yet).
    assign complete = (state == GRANT_I || state == GRANT_D) && !first_cyc && !MEM_BUSYWAIT;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (pick_d)
                    state_nxt = GRANT_D;
                else if (i_pend)
                    state_nxt = GRANT_I;
            end
            GRANT_I: if (complete) state_nxt = DONE_I;
            GRANT_D: if (complete) state_nxt = DONE_D;
            DONE_I:  state_nxt = IDLE;
            DONE_D:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        I_BUSYWAIT = i_pend && (state != DONE_I);
        D_BUSYWAIT = d_pend && (state != DONE_D);
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            first_cyc     <= 1'b0;
            MEM_READ      <= 1'b0;
            MEM_WRITE     <= 1'b0;
            MEM_ADDRESS   <= '0;
            MEM_WRITEDATA <= '0;
            I_READDATA    <= '0;
            D_READDATA    <= '0;
        end else begin
            first_cyc <= 1'b0;
            case (state)
                IDLE: begin
                    if (state_nxt == GRANT_D) begin
                        first_cyc     <= 1'b1;
                        MEM_ADDRESS   <= D_ADDRESS;
                        MEM_WRITEDATA <= D_WRITEDATA;
                        MEM_WRITE     <= D_WRITE;
                        MEM_READ      <= !D_WRITE;
                    end else if (state_nxt == GRANT_I) begin
                        first_cyc   <= 1'b1;
                        MEM_ADDRESS <= I_ADDRESS;
                        MEM_WRITE   <= 1'b0;
                        MEM_READ    <= 1'b1;
                    end
                end
                GRANT_I: begin
                    if (complete) begin
                        MEM_READ   <= 1'b0;
                        MEM_WRITE  <= 1'b0;
                        I_READDATA <= MEM_READDATA;
                    end
                end
                GRANT_D: begin
                    if (complete) begin
                        MEM_READ  <= 1'b0;
                        MEM_WRITE <= 1'b0;
                        if (MEM_READ)
                            D_READDATA <= MEM_READDATA;
                    end
                end
                default: begin
                    MEM_READ  <= 1'b0;
                    MEM_WRITE <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: transaction table plus back-to-back arbitration and mid-grant reset sequences.
module tb_mem_arbiter;

    localparam int AW = 28;
    localparam int BW = 128;

    logic          CLK;
    logic          RESET;
    logic          I_READ;
    logic [AW-1:0] I_ADDRESS;
    logic [BW-1:0] I_READDATA;
    logic          I_BUSYWAIT;
    logic          D_READ;
    logic          D_WRITE;
    logic [AW-1:0] D_ADDRESS;
    logic [BW-1:0] D_WRITEDATA;
    logic [BW-1:0] D_READDATA;
    logic          D_BUSYWAIT;
    logic          MEM_READ;
    logic          MEM_WRITE;
    logic [AW-1:0] MEM_ADDRESS;
    logic [BW-1:0] MEM_WRITEDATA;
    logic [BW-1:0] MEM_READDATA;
    logic          MEM_BUSYWAIT;

    mem_arbiter #(.ADDR_W(AW), .BLOCK_W(BW)) dut (
        .CLK(CLK), .RESET(RESET),
        .I_READ(I_READ), .I_ADDRESS(I_ADDRESS), .I_READDATA(I_READDATA), .I_BUSYWAIT(I_BUSYWAIT),
        .D_READ(D_READ), .D_WRITE(D_WRITE), .D_ADDRESS(D_ADDRESS), .D_WRITEDATA(D_WRITEDATA),
        .D_READDATA(D_READDATA), .D_BUSYWAIT(D_BUSYWAIT),
        .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .MEM_ADDRESS(MEM_ADDRESS),
        .MEM_WRITEDATA(MEM_WRITEDATA), .MEM_READDATA(MEM_READDATA), .MEM_BUSYWAIT(MEM_BUSYWAIT)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Memory: busy for mem_lat cycles counted from the first cycle the operation is presented.
    int mem_cnt = 0;
    int mem_lat = 0;
    always_ff @(posedge CLK) begin
        if (MEM_READ || MEM_WRITE)
            mem_cnt <= mem_cnt + 1;
        else
            mem_cnt <= 0;
    end
    assign MEM_BUSYWAIT = (MEM_READ || MEM_WRITE) && (mem_cnt < mem_lat);

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        n_total++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    typedef struct {
        logic          i_rd;
        logic          d_rd;
        logic          d_wr;
        logic [AW-1:0] i_addr;
        logic [AW-1:0] d_addr;
        logic [BW-1:0] wdata;
        logic [BW-1:0] rdata;
        int            lat;
        logic          gnt_d;
        int            cycles;
        logic [BW-1:0] exp_i;
        logic [BW-1:0] exp_d;
    } vec_t;

    localparam logic [BW-1:0] P_A    = {32{4'hA}};
    localparam logic [BW-1:0] P_1234 = {8{16'h1234}};
    localparam logic [BW-1:0] P_5    = {32{4'h5}};
    localparam logic [BW-1:0] P_CAFE = {8{16'hCAFE}};
    localparam logic [BW-1:0] P_DEAD = {8{16'hDEAD}};
    localparam logic [BW-1:0] P_7    = {32{4'h7}};
    localparam logic [BW-1:0] P_0F   = {16{8'h0F}};

    vec_t vecs[6];
    int   cycles, op_cnt, bad_op, bad_dat, loser_bad;
    logic done, is_wr, gb, lb;
    logic [1:0] exp_op;
    logic [AW-1:0] exp_addr;
    int   order[$];

    initial begin
        vecs[0] = '{1'b1, 1'b0, 1'b0, 28'h0000010, 28'h0, '0, P_A, 4, 1'b0, 6, P_A, '0};
        vecs[1] = '{1'b0, 1'b0, 1'b1, 28'h0, 28'h0000020, P_1234, P_DEAD, 2, 1'b1, 4, P_A, '0};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 28'h0, 28'h0000030, '0, P_5, 0, 1'b1, 3, P_A, P_5};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 28'h0, 28'h0000040, P_CAFE, P_DEAD, 1, 1'b1, 3, P_A, P_5};
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
        vecs[4] = '{1'b1, 1'b1, 1'b0, 28'h0000044, 28'h0000048, '0, P_7, 1, 1'b0, 3, P_7, P_5};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 28'h0000050, 28'h0, '0, P_0F, 3, 1'b0, 5, P_0F, P_5};
`else
        vecs[4] = '{1'b1, 1'b1, 1'b0, 28'h0000044, 28'h0000048, '0, P_7, 1, 1'b1, 3, P_A, P_7};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 28'h0000050, 28'h0, '0, P_0F, 3, 1'b0, 5, P_0F, P_7};
`endif

        RESET = 1'b0; I_READ = 1'b1; D_READ = 1'b0; D_WRITE = 1'b0;
        I_ADDRESS = '0; D_ADDRESS = '0; D_WRITEDATA = '0; MEM_READDATA = '0;
        #3;
        check("rst_mem_op", 128'({MEM_READ, MEM_WRITE}), 128'(2'b00));
        check("rst_mem_addr", 128'(MEM_ADDRESS), '0);
        check("rst_mem_wdata", MEM_WRITEDATA, '0);
        check("rst_readdata", I_READDATA | D_READDATA, '0);
        check("rst_busy_pending", 128'({I_BUSYWAIT, D_BUSYWAIT}), 128'(2'b10));
        I_READ = 1'b0;
        repeat (2) @(negedge CLK);
        RESET = 1'b1;

        for (int v = 0; v < 6; v++) begin
            @(negedge CLK);
            I_READ = vecs[v].i_rd; D_READ = vecs[v].d_rd; D_WRITE = vecs[v].d_wr;
            I_ADDRESS = vecs[v].i_addr; D_ADDRESS = vecs[v].d_addr; D_WRITEDATA = vecs[v].wdata;
            MEM_READDATA = vecs[v].rdata; mem_lat = vecs[v].lat;
            is_wr    = vecs[v].gnt_d && vecs[v].d_wr;
            exp_op   = is_wr ? 2'b01 : 2'b10;
            exp_addr = vecs[v].gnt_d ? vecs[v].d_addr : vecs[v].i_addr;
            #1;
            check($sformatf("v%0d_busy_req", v), 128'({I_BUSYWAIT, D_BUSYWAIT}),
                  128'({vecs[v].i_rd, vecs[v].d_rd | vecs[v].d_wr}));
            cycles = 0; op_cnt = 0; bad_op = 0; bad_dat = 0; loser_bad = 0; done = 1'b0;
            while (!done && cycles < 40) begin
                @(negedge CLK);
                cycles++;
                gb = vecs[v].gnt_d ? D_BUSYWAIT : I_BUSYWAIT;
                lb = vecs[v].gnt_d ? I_BUSYWAIT : D_BUSYWAIT;
                if (vecs[v].i_rd && vecs[v].d_rd && !lb)
                    loser_bad++;
                if (MEM_READ || MEM_WRITE) begin
                    op_cnt++;
                    if ({MEM_READ, MEM_WRITE} != exp_op) bad_op++;
                    if (MEM_ADDRESS != exp_addr) bad_dat++;
                    if (is_wr && MEM_WRITEDATA != vecs[v].wdata) bad_dat++;
                    I_ADDRESS = 28'h0000FFF; D_ADDRESS = 28'h0000FFF; D_WRITEDATA = '0;
                end
                if (!gb) done = 1'b1;
            end
            check($sformatf("v%0d_done", v), 128'(done), 128'(1'b1));
            check($sformatf("v%0d_latency", v), 128'(cycles), 128'(vecs[v].cycles));
            check($sformatf("v%0d_op_cycles", v), 128'(op_cnt), 128'(vecs[v].cycles - 1));
            check($sformatf("v%0d_op_kind", v), 128'(bad_op), '0);
            check($sformatf("v%0d_addr_wdata_held", v), 128'(bad_dat), '0);
            check($sformatf("v%0d_loser_stalled", v), 128'(loser_bad), '0);
            check($sformatf("v%0d_i_readdata", v), I_READDATA, vecs[v].exp_i);
            check($sformatf("v%0d_d_readdata", v), D_READDATA, vecs[v].exp_d);
            I_READ = 1'b0; D_READ = 1'b0; D_WRITE = 1'b0;
            @(negedge CLK);
            check($sformatf("v%0d_idle_after", v), 128'({MEM_READ, MEM_WRITE, I_BUSYWAIT, D_BUSYWAIT}), '0);
        end

        // Both ports held continuously: record which port is released on each grant.
        @(negedge CLK);
        I_READ = 1'b1; D_READ = 1'b1; mem_lat = 1;
        D_ADDRESS = 28'h0000070; I_ADDRESS = 28'h0000074;
        for (int c = 0; c < 60 && order.size() < 4; c++) begin
            @(negedge CLK);
            if (!D_BUSYWAIT) order.push_back(1);
            if (!I_BUSYWAIT) order.push_back(0);
        end
        check("b2b_grant_count", 128'(order.size()), 128'(4));
        for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
            check($sformatf("b2b_grant%0d_is_d", k), 128'((k < order.size()) ? order[k] : 2), 128'((k % 2 == 0) ? 1 : 0));
`else
            check($sformatf("b2b_grant%0d_is_d", k), 128'((k < order.size()) ? order[k] : 2), 128'(1));
`endif
        end
        I_READ = 1'b0; D_READ = 1'b0;
        repeat (3) @(negedge CLK);

        // Reset pulled during a busy D grant, request kept across release.
        D_READ = 1'b1; D_ADDRESS = 28'h0000060; mem_lat = 20; MEM_READDATA = P_DEAD;
        repeat (2) @(negedge CLK);
        check("rst_mid_pre_read", 128'(MEM_READ), 128'(1'b1));
        #1 RESET = 1'b0;
        #1;
        check("rst_mid_mem_op", 128'({MEM_READ, MEM_WRITE}), '0);
        check("rst_mid_mem_addr", 128'(MEM_ADDRESS), '0);
        check("rst_mid_readdata", I_READDATA | D_READDATA, '0);
        check("rst_mid_d_busy", 128'(D_BUSYWAIT), 128'(1'b1));
        @(negedge CLK);
        RESET = 1'b1;
        mem_lat = 0;
        @(negedge CLK);
        check("rst_regrant_op", 128'({MEM_READ, MEM_WRITE}), 128'(2'b10));
        check("rst_regrant_addr", 128'(MEM_ADDRESS), 128'(28'h0000060));
        done = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge CLK);
            if (!D_BUSYWAIT) done = 1'b1;
        end
        check("rst_regrant_done", 128'(done), 128'(1'b1));
        check("rst_regrant_data", D_READDATA, P_DEAD);
        D_READ = 1'b0;
        repeat (2) @(negedge CLK);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 28, meaning the cache block-address width.
REQ-002 The block SHALL have parameter BLOCK_W, default 128, meaning the cache block data width.
REQ-003 Port CLK  in  1  SHALL be the single clock; all state changes on the rising edge.
REQ-004 Port RESET  in  1  SHALL be the asynchronous, active-low reset.
REQ-005 Port I_READ  in  1  SHALL be the instruction-cache block-read request.
REQ-006 Port I_ADDRESS  in  ADDR_W  SHALL be the instruction-cache block address.
REQ-007 Port I_READDATA  out  BLOCK_W  SHALL be the block returned to the instruction cache.
REQ-008 Port I_BUSYWAIT  out  1  SHALL be the stall signal to the instruction cache.
REQ-009 Ports D_READ  in  1 and D_WRITE  in  1  SHALL be the data-cache block-read and block-write (writeback) requests.
REQ-010 Ports D_ADDRESS  in  ADDR_W and D_WRITEDATA  in  BLOCK_W  SHALL be the data-cache block address and writeback data.
REQ-011 Ports D_READDATA  out  BLOCK_W and D_BUSYWAIT  out  1  SHALL be the data-cache return block and stall.
REQ-012 Ports MEM_READ  out  1, MEM_WRITE  out  1, MEM_ADDRESS  out  ADDR_W, MEM_WRITEDATA  out  BLOCK_W SHALL drive the shared main memory.
REQ-013 Ports MEM_READDATA  in  BLOCK_W and MEM_BUSYWAIT  in  1  SHALL be the main-memory return data and stall.

Function
REQ-014 FSM states SHALL be IDLE, GRANT_I, GRANT_D, DONE_I, DONE_D.
REQ-015 In IDLE, a requester is pending when I_READ=1 (I) or D_READ|D_WRITE=1 (D); with none pending the FSM SHALL stay in IDLE.
REQ-016 In IDLE, with one requester pending the FSM SHALL move to that requester's GRANT state on the next edge; with both pending, priority is per REQ-030/031.
REQ-017 On entry to GRANT_x the block SHALL register the requester's address, write data and operation into MEM_* outputs; later requester input changes SHALL NOT affect MEM_* until the next grant.
REQ-018 When D_READ=1 and D_WRITE=1 together, the grant SHALL perform a write only (MEM_WRITE=1, MEM_READ=0).
REQ-019 MEM_READ/MEM_WRITE SHALL be held at 1 throughout GRANT_x, including the first grant cycle.
REQ-020 Completion SHALL be a rising edge in GRANT_x at which MEM_BUSYWAIT=0 and the FSM has been in GRANT_x for at least one full cycle; the first-cycle value of MEM_BUSYWAIT SHALL be ignored.
REQ-021 At the completion edge the FSM SHALL go to DONE_x, deassert MEM_READ/MEM_WRITE, and for a read capture MEM_READDATA into x_READDATA.
REQ-022 x_READDATA SHALL hold its value except at a read completion for port x; a write completion SHALL NOT change D_READDATA.
REQ-023 From DONE_x the FSM SHALL go to IDLE on the next edge unconditionally.
REQ-024 x_BUSYWAIT SHALL equal (port x pending) AND NOT (state = DONE_x), combinationally from inputs and state.
REQ-025 A requester dropping its request during GRANT_x SHALL NOT abort the transaction; the FSM SHALL wait for completion, pass through DONE_x, and return to IDLE.
REQ-026 Minimum request-to-busywait-release latency SHALL be 3 cycles (IDLE->GRANT_x, one grant cycle, completion->DONE_x).

Reset
REQ-027 RESET=0 SHALL immediately force state IDLE, MEM_READ=0, MEM_WRITE=0, MEM_ADDRESS=0, MEM_WRITEDATA=0, I_READDATA=0, D_READDATA=0, and the round-robin pointer (if present) to "I last served".
REQ-028 During reset x_BUSYWAIT SHALL follow REQ-024 (1 if port x pending, else 0).
REQ-029 Reset asserted mid-transaction SHALL abandon it; after release the requester still pending SHALL be re-granted from IDLE.

Configuration
REQ-030 Without macro MEM_ARBITER_ROUND_ROBIN_EN, simultaneous requests in IDLE SHALL grant D (fixed data-priority).
REQ-031 With MEM_ARBITER_ROUND_ROBIN_EN defined, a 1-bit last-served register updated on each grant SHALL give the tie to the port not last served; single-request behaviour SHALL be unchanged.

Verification
REQ-032 Single I read, addr 0x0000010, memory busy 4 cycles returning 0xAAAA...AAAA -> MEM_READ=1 for 5 cycles, I_READDATA=0xAAAA...AAAA in DONE_I, I_BUSYWAIT low exactly one cycle.
REQ-033 D_WRITE addr 0x0000020 data 0x1234...; D_ADDRESS changed to 0x0000FFF mid-grant -> MEM_ADDRESS stays 0x0000020, D_READDATA unchanged.
REQ-034 I_READ and D_READ asserted same cycle, repeated back-to-back, macro off -> D granted every time, I_BUSYWAIT stays 1; macro on -> grants alternate D, I, D, I.
REQ-035 D_READ=1 with D_WRITE=1 -> MEM_WRITE=1, MEM_READ=0 for entire grant.
REQ-036 RESET pulled to 0 during GRANT_D with MEM_BUSYWAIT=1 -> all MEM_* outputs 0 same cycle; after release with D_READ still 1 -> new GRANT_D next edge.
